reverse_sched: RTL
==================

Name: reverse_sched

Overview:
- Round-robin scheduler that shares one bit-reverse datapath between NUM streaming requesters.
- Each requester sends packets of DIN-bit words; each word carries an eot flag on its last beat.
- The scheduler grants one requester at a time and holds the grant for a whole packet (until its eot beat).
- Each word is bit-reversed (bit i of output = bit DIN-1-i of input), registered into a one-entry output stage, and tagged with the source id.
- Sits between per-channel producers and a single downstream consumer.

Parameters:
- DIN, 16, data word width in bits (≥1)
- NUM, 2, number of requesters (≥2)
- IDW, max(1,clog2(NUM)), width of source-id tag (derived localparam)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- din_valid  input  NUM  per-requester valid
- din_ready  output  NUM  per-requester ready
- din_data  input  NUM*DIN  requester k uses bits [k*DIN +: DIN]
- din_eot  input  NUM  per-requester last-beat flag
- dout_valid  output  1  output word valid
- dout_ready  input  1  downstream ready
- dout_data  output  DIN  bit-reversed word
- dout_eot  output  1  eot of the forwarded word
- dout_id  output  IDW  index of the requester that sent the word
- lock_timeout  output  1  only when REVERSE_SCHED_TIMEOUT_EN is defined

Behaviour:
- Async reset clears dout_valid=0, dout_data=0, dout_eot=0, dout_id=0, state=IDLE, ptr=NUM-1, lock_id=0, lock_timeout=0, timeout counter=0.
- Output register can accept when !dout_valid || dout_ready (accept = take).
- FSM states:
  - IDLE: grant = first k with din_valid[k]=1, searching ptr+1, ptr+2, … modulo NUM. No grant if no valid.
  - LOCKED: grant = lock_id only, regardless of other valids.
- Handshakes:
  - din_ready[k] = take && (grant==k); all other bits of din_ready are 0. At most one bit of din_ready is high.
  - A transfer on requester k loads the output register: dout_data=reverse(word k), dout_eot=din_eot[k], dout_id=k, dout_valid=1.
  - Latency is 1 cycle from input handshake to dout_valid.
  - Full throughput when dout_ready is held at 1.
- If take=1 with no input transfer: dout_valid clears when dout_ready=1, otherwise holds. Output is stable while dout_valid && !dout_ready.
- Transfer with eot=1: next state is IDLE and ptr is set to k, so the following arbitration starts at k+1.
- Transfer with eot=0 in IDLE: go to LOCKED with lock_id=k.
- Transfer with eot=0 in LOCKED: stay LOCKED.
- Single-beat packets (eot=1 on the first beat) never enter LOCKED.
- Wrap-around: when ptr=NUM-1, the search starts at 0.
- A requester not granted must hold valid/data/eot stable; the scheduler does not require this for correctness.
- Simultaneous events: an input transfer and a downstream pop in the same cycle both happen, so the output register is replaced.
- dout_ready=0 with a full output stage: all din_ready are 0 and state does not change.
- Reset asserted mid-packet returns to IDLE at once. The partial packet is dropped from the scheduler's view, and the output stage is emptied.

Optional Feature:
- Macro: REVERSE_SCHED_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 16) and output lock_timeout.
  - A counter runs while in LOCKED and din_valid[lock_id]=0. It resets to 0 on any cycle where din_valid[lock_id]=1, and in IDLE.
  - When the counter reaches TIMEOUT: lock_timeout pulses high for exactly 1 cycle, state goes to IDLE, and ptr=lock_id.
  - The abandoned packet is not terminated downstream; no eot is inserted.
- When not defined: no counter and no lock_timeout port. A LOCKED requester holds the grant indefinitely.

Test Plan:
- NUM=2, DIN=16. Req0 sends single word 0x0001 eot=1, dout_ready=1. Expect dout_data=0x8000, dout_eot=1, dout_id=0 one cycle later.
- Both requesters continuously valid, all single-beat, dout_ready=1. Expect dout_id alternating 0,1,0,1 with one word per cycle.
- Req0 sends a 3-beat packet (0x00FF, 0x0F0F, 0xAAAA eot) while req1 is valid throughout. Expect outputs 0xFF00, 0xF0F0, 0x5555 all with id 0, then req1 granted. din_ready[1]=0 during the packet.
- dout_ready=0 for 4 cycles with the output full. Expect dout_data/eot/id stable and din_ready=0. On release, transfers resume with no loss or duplication.
- Reset asserted while LOCKED mid-packet. Expect dout_valid=0 immediately and state IDLE. After reset, req1 (ptr=NUM-1 → search from 0, only req1 valid) is granted.
- With REVERSE_SCHED_TIMEOUT_EN and TIMEOUT=4: req0 sends 1 beat eot=0, then drops valid while req1 is valid. Expect lock_timeout pulse on the 4th idle cycle, then req1 granted the next cycle.

Source files
------------

// File: rtl/reverse_sched.sv
// Round-robin scheduler sharing one bit-reverse datapath among NUM packet requesters.
// Optional lock watchdog enabled by defining REVERSE_SCHED_TIMEOUT_EN (adds TIMEOUT and lock_timeout).
module reverse_sched #(
   parameter int DIN = 16,
   parameter int NUM = 2,
`ifdef REVERSE_SCHED_TIMEOUT_EN
   parameter int TIMEOUT = 16,
`endif
   localparam int IDW = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM-1:0]     din_valid,
   output logic [NUM-1:0]     din_ready,
   input  logic [NUM*DIN-1:0] din_data,
   input  logic [NUM-1:0]     din_eot,
   output logic               dout_valid,
   input  logic               dout_ready,
   output logic [DIN-1:0]     dout_data,
   output logic               dout_eot,
   output logic [IDW-1:0]     dout_id
`ifdef REVERSE_SCHED_TIMEOUT_EN
   ,
   output logic               lock_timeout
`endif
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   lock_id;
   logic [IDW-1:0]   grant;
   logic [IDW-1:0]   cand;
   logic             grant_valid;
   logic             take;
   logic             xfer;
   logic             eot;
   logic [DIN-1:0]   words [NUM];
   logic [DIN-1:0]   word;
   logic [DIN-1:0]   rev;

`ifdef REVERSE_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]    tcnt;
`endif

   for (genvar k = 0; k < NUM; k++) begin : g_words
      assign words[k] = din_data[k*DIN +: DIN];
   end

   assign word = words[grant];
   assign eot  = din_eot[grant];

   for (genvar b = 0; b < DIN; b++) begin : g_rev
      assign rev[b] = word[DIN-1-b];
   end

   assign take = !dout_valid || dout_ready;
   assign xfer = take && grant_valid && din_valid[grant];

   // Round-robin search starts one past the last requester that finished a packet.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      cand        = ptr;
      if (state == LOCKED) begin
         grant_valid = 1'b1;
         grant       = lock_id;
      end else begin
         for (int i = 0; i < NUM; i++) begin
            cand = (cand == IDW'(NUM - 1)) ? '0 : cand + 1'b1;
            if (!grant_valid && din_valid[cand]) begin
               grant_valid = 1'b1;
               grant       = cand;
            end
         end
      end
   end

   always_comb begin
      din_ready = '0;
      if (take && grant_valid) din_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_eot   <= 1'b0;
         dout_id    <= '0;
         state      <= IDLE;
         ptr        <= IDW'(NUM - 1);
         lock_id    <= '0;
`ifdef REVERSE_SCHED_TIMEOUT_EN
         lock_timeout <= 1'b0;
         tcnt         <= '0;
`endif
      end else begin
         if (xfer) begin
            dout_valid <= 1'b1;
            dout_data  <= rev;
            dout_eot   <= eot;
            dout_id    <= grant;
         end else if (dout_ready) begin
            dout_valid <= 1'b0;
         end

         if (xfer) begin
            if (eot) begin
               state <= IDLE;
               ptr   <= grant;
            end else begin
               state   <= LOCKED;
               lock_id <= grant;
            end
         end

`ifdef REVERSE_SCHED_TIMEOUT_EN
         // A starved lock is abandoned once the idle counter would reach TIMEOUT.
         lock_timeout <= 1'b0;
         if (state == LOCKED && !din_valid[lock_id]) begin
            if (tcnt == TW'(TIMEOUT - 1)) begin
               lock_timeout <= 1'b1;
               state        <= IDLE;
               ptr          <= lock_id;
               tcnt         <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end else begin
            tcnt <= '0;
         end
`endif
      end
   end

endmodule
